enemy_spawn_scheduler: RTL and testbench

//  Decides when and where enemies appear. Loads a frame-based spawn delay from the PRBS word, counts

---
 rtl/enemy_spawn_if.sv | 21 ++
 rtl/enemy_spawn_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_enemy_spawn_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_spawn_if.sv
// Spawn handshake between the scheduler (master) and the enemy datapath (slave).
// spawn_req is held with a stable spawn_idx until the slave returns spawn_ack.
interface enemy_spawn_if #(
   parameter int unsigned IDX_W = 2
);
   logic             spawn_req;
   logic [IDX_W-1:0] spawn_idx;
   logic             spawn_ack;

   modport master (
      output spawn_req,
      output spawn_idx,
      input  spawn_ack
   );

   modport slave (
      input  spawn_req,
      input  spawn_idx,
      output spawn_ack
   );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: waits a PRBS-derived number of frames, picks a free enemy slot
// (biased by the PRBS slot field), requests the spawn over a req/ack handshake and tracks
// which slots are alive.
// Optional build macro SPAWN_RAMP_EN: the loaded delay is shifted right by a ramp that
// grows by one every 8 completed spawns (cap 3), restarting whenever the scheduler idles.
module enemy_spawn_scheduler #(
   parameter int unsigned SPAWN_COUNTER_SIZE = 8,
   parameter int unsigned NBR_ENEMIES        = 4,
   parameter int unsigned MIN_DELAY          = 8,
   parameter int unsigned IDX_W              = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   pixel_0_line_0,
   input  logic                                   game_en,
   input  logic [SPAWN_COUNTER_SIZE+NBR_ENEMIES-1:0] prbs_val,
   input  logic [NBR_ENEMIES-1:0]                 enemy_killed,
   enemy_spawn_if.master                          spawn,
   output logic [NBR_ENEMIES-1:0]                 alive_mask,
   output logic [15:0]                            spawn_count
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StCount    = 3'd1;
   localparam logic [2:0] StSearch   = 3'd2;
   localparam logic [2:0] StWaitFree = 3'd3;
   localparam logic [2:0] StReq      = 3'd4;

   localparam logic [SPAWN_COUNTER_SIZE-1:0] MinDelayW = SPAWN_COUNTER_SIZE'(MIN_DELAY);

   logic [2:0]                    state_q, state_d;
   logic [SPAWN_COUNTER_SIZE-1:0] counter_q, counter_d;
   logic                          req_q, req_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [NBR_ENEMIES-1:0]        alive_q, alive_d;
   logic [15:0]                   count_q, count_d;

   logic [SPAWN_COUNTER_SIZE-1:0] prbs_delay;
   logic [SPAWN_COUNTER_SIZE-1:0] delay_raw;
   logic [SPAWN_COUNTER_SIZE-1:0] load_delay;
   logic [NBR_ENEMIES-1:0]        slot_field;
   logic [NBR_ENEMIES-1:0]        free_slots;
   logic [NBR_ENEMIES-1:0]        pick_src;
   logic [IDX_W-1:0]              pick_idx;
   logic                          ack_fire;

   assign prbs_delay = prbs_val[SPAWN_COUNTER_SIZE-1:0];
   assign slot_field = prbs_val[SPAWN_COUNTER_SIZE+NBR_ENEMIES-1 -: NBR_ENEMIES];
   assign free_slots = ~alive_q;
   // Prefer a free slot the PRBS field points at; otherwise any free slot
   assign pick_src   = ((free_slots & slot_field) != '0) ? (free_slots & slot_field) : free_slots;
   // An ack only counts once the request is actually visible on the bus
   assign ack_fire   = (state_q == StReq) && req_q && spawn.spawn_ack;

`ifdef SPAWN_RAMP_EN
   logic [1:0] ramp_shift_q, ramp_shift_d;
   logic [2:0] ramp_cnt_q, ramp_cnt_d;

   // Ramp bookkeeping: cleared while idle, shift steps once per 8 completed spawns up to 3
   always_comb begin
      ramp_shift_d = ramp_shift_q;
      ramp_cnt_d   = ramp_cnt_q;
      if (state_q == StIdle) begin
         ramp_shift_d = '0;
         ramp_cnt_d   = '0;
      end else if (ack_fire) begin
         ramp_cnt_d = ramp_cnt_q + 3'd1;
         if ((ramp_cnt_q == 3'd7) && (ramp_shift_q != 2'd3)) begin
            ramp_shift_d = ramp_shift_q + 2'd1;
         end
      end
   end

   // Ramp state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramp_shift_q <= '0;
         ramp_cnt_q   <= '0;
      end else begin
         ramp_shift_q <= ramp_shift_d;
         ramp_cnt_q   <= ramp_cnt_d;
      end
   end

   // The delay loaded on an ack already uses the shift that includes this spawn
   assign delay_raw = prbs_delay >> ramp_shift_d;
`else
   assign delay_raw = prbs_delay;
`endif

   assign load_delay = (delay_raw < MinDelayW) ? MinDelayW : delay_raw;

   // Lowest set bit of the chosen candidate set
   always_comb begin
      pick_idx = '0;
      for (int i = NBR_ENEMIES - 1; i >= 0; i--) begin
         if (pick_src[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   // Scheduler next-state: delay countdown, slot search and spawn handshake
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      req_d     = req_q;
      idx_d     = idx_q;
      count_d   = count_q;
      alive_d   = alive_q & ~enemy_killed;
      case (state_q)
         StIdle: begin
            if (game_en) begin
               counter_d = load_delay;
               state_d   = StCount;
            end
         end
         StCount: begin
            if (!game_en) begin
               state_d = StIdle;
            end else if (pixel_0_line_0) begin
               if (counter_q == '0) begin
                  state_d = StSearch;
               end else begin
                  counter_d = counter_q - 1'b1;
               end
            end
         end
         StSearch, StWaitFree: begin
            if (!game_en) begin
               state_d = StIdle;
            end else if (free_slots != '0) begin
               idx_d   = pick_idx;
               state_d = StReq;
            end else begin
               state_d = StWaitFree;
            end
         end
         StReq: begin
            // Handshake always completes, even if the game is disabled meanwhile
            if (!req_q) begin
               req_d = 1'b1;
            end else if (ack_fire) begin
               alive_d[idx_q] = 1'b1;
               count_d        = count_q + 16'd1;
               counter_d      = load_delay;
               req_d          = 1'b0;
               state_d        = game_en ? StCount : StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   // Scheduler state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         counter_q <= '0;
         req_q     <= 1'b0;
         idx_q     <= '0;
         alive_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         req_q     <= req_d;
         idx_q     <= idx_d;
         alive_q   <= alive_d;
         count_q   <= count_d;
      end
   end

   assign spawn.spawn_req = req_q;
   assign spawn.spawn_idx = idx_q;
   assign alive_mask      = alive_q;
   assign spawn_count     = count_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Self-checking bench for enemy_spawn_scheduler: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_enemy_spawn_scheduler;

   localparam int IW = 2;

   localparam int PIdle   = 0;
   localparam int PCount  = 1;
   localparam int PSearch = 2;
   localparam int PWait   = 3;
   localparam int PReq    = 4;

   typedef struct {
      int       phase;
      int       cnt;
      bit       req;
      int       idx;
      bit [3:0] alive;
      int       count;
      int       nsp;
   } mstate_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pixel = 1'b0;
   logic        game_en = 1'b0;
   logic [11:0] prbs_val = '0;
   logic [3:0]  kill = '0;
   logic [3:0]  alive_mask;
   logic [15:0] spawn_count;

   int checks = 0;
   int errors = 0;

   mstate_t m;

   enemy_spawn_if #(.IDX_W(IW)) spawn_bus ();

   enemy_spawn_scheduler #(
      .SPAWN_COUNTER_SIZE(8),
      .NBR_ENEMIES       (4),
      .MIN_DELAY         (8),
      .IDX_W             (IW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pixel_0_line_0(pixel),
      .game_en       (game_en),
      .prbs_val      (prbs_val),
      .enemy_killed  (kill),
      .spawn         (spawn_bus),
      .alive_mask    (alive_mask),
      .spawn_count   (spawn_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Frames to wait for a spawn given PRBS delay d and the number of spawns since idle
   function automatic int frames_for(input int d, input int done);
      int sh;
      int v;
      sh = 0;
`ifdef SPAWN_RAMP_EN
      sh = (done / 8 > 3) ? 3 : done / 8;
`endif
      v = d >> sh;
      return (v < 8) ? 8 : v;
   endfunction

   // Free slot choice: lowest free slot named by the field, else lowest free slot
   function automatic int choose_slot(input bit [3:0] free, input bit [3:0] field);
      for (int i = 0; i < 4; i++) if (free[i] && field[i]) return i;
      for (int i = 0; i < 4; i++) if (free[i]) return i;
      return 0;
   endfunction

   function automatic mstate_t model_reset();
      mstate_t s;
      s.phase = PIdle; s.cnt = 0; s.req = 0; s.idx = 0; s.alive = '0; s.count = 0; s.nsp = 0;
      return s;
   endfunction

   function automatic mstate_t model_next(input mstate_t s, input bit en, input bit tick,
                                          input bit [11:0] pv, input bit [3:0] kl, input bit ack);
      mstate_t n;
      bit [3:0] free;
      n = s;
      free = ~s.alive;
      n.alive = s.alive & ~kl;
      if (s.phase == PIdle) begin
         n.nsp = 0;
         if (en) begin
            n.cnt = frames_for(int'(pv[7:0]), 0);
            n.phase = PCount;
         end
      end else if (s.phase == PCount) begin
         if (!en) n.phase = PIdle;
         else if (tick) begin
            if (s.cnt == 0) n.phase = PSearch;
            else n.cnt = s.cnt - 1;
         end
      end else if (s.phase == PSearch || s.phase == PWait) begin
         if (!en) n.phase = PIdle;
         else if (free != 4'b0) begin
            n.idx = choose_slot(free, pv[11:8]);
            n.phase = PReq;
         end else n.phase = PWait;
      end else begin
         if (!s.req) n.req = 1;
         else if (ack) begin
            n.alive[s.idx] = 1'b1;
            n.count = (s.count + 1) % 65536;
            n.nsp = s.nsp + 1;
            n.cnt = frames_for(int'(pv[7:0]), s.nsp + 1);
            n.req = 0;
            n.phase = en ? PCount : PIdle;
         end
      end
      return n;
   endfunction

   // Reference model advances on the same edges as the design
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else m <= model_next(m, game_en, pixel, prbs_val, kill, spawn_bus.spawn_ack);
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         check("model_req", {31'b0, spawn_bus.spawn_req}, {31'b0, m.req});
         check("model_idx", {30'b0, spawn_bus.spawn_idx}, m.idx);
         check("model_alive", {28'b0, alive_mask}, {28'b0, m.alive});
         check("model_count", {16'b0, spawn_count}, m.count);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (spawn_bus.spawn_req !== 1'b1 && n < budget);
      if (spawn_bus.spawn_req !== 1'b1) check("req_timeout", {31'b0, spawn_bus.spawn_req}, 1);
   endtask

   task automatic do_ack(input logic [11:0] next_prbs);
      spawn_bus.spawn_ack = 1'b1;
      prbs_val = next_prbs;
      step();
      spawn_bus.spawn_ack = 1'b0;
   endtask

   function automatic int ramp_literal(input int done);
`ifdef SPAWN_RAMP_EN
      if (done < 8) return 200;
      if (done < 16) return 100;
      if (done < 24) return 50;
      return 25;
`else
      return 200;
`endif
   endfunction

   initial begin
      int n;
      spawn_bus.spawn_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {31'b0, spawn_bus.spawn_req}, 0);
      check("rst_idx", {30'b0, spawn_bus.spawn_idx}, 0);
      check("rst_alive", {28'b0, alive_mask}, 0);
      check("rst_count", {16'b0, spawn_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Delay 3 is floored to 8: 9 ticks to SEARCH, then 2 clocks to spawn_req
      prbs_val = {4'b0110, 8'd3};
      game_en = 1'b1;
      pixel = 1'b1;
      wait_req(100, n);
      check("t1_latency", n, 12);
      check("t1_idx", {30'b0, spawn_bus.spawn_idx}, 1);
      do_ack({4'b0110, 8'd3});
      check("t1_alive", {28'b0, alive_mask}, 4'b0010);
      check("t1_count", {16'b0, spawn_count}, 1);

      // Same field with slot 1 taken selects slot 2
      wait_req(100, n);
      check("t2_latency", n, 11);
      check("t2_idx", {30'b0, spawn_bus.spawn_idx}, 2);
      do_ack({4'b0001, 8'd3});
      wait_req(100, n);
      check("t2_idx0", {30'b0, spawn_bus.spawn_idx}, 0);
      do_ack({4'b1000, 8'd3});
      wait_req(100, n);
      check("t2_idx3", {30'b0, spawn_bus.spawn_idx}, 3);
      do_ack({4'b1000, 8'd3});
      check("t2_full", {28'b0, alive_mask}, 4'b1111);

      // All slots taken: no request until a kill frees slot 2
      repeat (30) step();
      check("t3_noreq", {31'b0, spawn_bus.spawn_req}, 0);
      kill = 4'b0100;
      step();
      kill = 4'b0000;
      check("t3_alive", {28'b0, alive_mask}, 4'b1011);
      step();
      check("t3_idx", {30'b0, spawn_bus.spawn_idx}, 2);
      check("t3_req_low", {31'b0, spawn_bus.spawn_req}, 0);
      step();
      check("t3_req_high", {31'b0, spawn_bus.spawn_req}, 1);

      // Stalled handshake survives game_en dropping; completes into IDLE
      for (int i = 0; i < 20; i++) begin
         if (i == 5) game_en = 1'b0;
         step();
         check("t4_req_hold", {31'b0, spawn_bus.spawn_req}, 1);
         check("t4_idx_hold", {30'b0, spawn_bus.spawn_idx}, 2);
      end
      do_ack({4'b1000, 8'd3});
      check("t4_alive", {28'b0, alive_mask}, 4'b1111);
      check("t4_count", {16'b0, spawn_count}, 5);
      repeat (30) step();
      check("t4_idle", {31'b0, spawn_bus.spawn_req}, 0);

      // Kill and ack on the spawned slot in the same cycle: slot stays alive
      kill = 4'b1000;
      step();
      kill = 4'b0000;
      check("t5_freed", {28'b0, alive_mask}, 4'b0111);
      game_en = 1'b1;
      wait_req(100, n);
      check("t5_latency", n, 12);
      check("t5_idx", {30'b0, spawn_bus.spawn_idx}, 3);
      kill = 4'b1000;
      do_ack({4'b1000, 8'd3});
      kill = 4'b0000;
      check("t5_alive", {28'b0, alive_mask}, 4'b1111);
      check("t5_count", {16'b0, spawn_count}, 6);

      // Fixed d=200 over 25 spawns; every slot freed each cycle
      game_en = 1'b0;
      step();
      step();
      kill = 4'hF;
      prbs_val = {4'hF, 8'd200};
      game_en = 1'b1;
      wait_req(1000, n);
      check("t6_first", n, 204);
      for (int k = 1; k <= 24; k++) begin
         do_ack({4'hF, 8'd200});
         wait_req(1000, n);
         check($sformatf("t6_delay_%0d", k + 1), n - 3, ramp_literal(k));
      end

      // Asynchronous reset mid-handshake drops the request without a clock edge
      #1;
      rst_n = 1'b0;
      #1;
      check("async_req", {31'b0, spawn_bus.spawn_req}, 0);
      check("async_count", {16'b0, spawn_count}, 0);
      kill = 4'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Randomized traffic against the model
      game_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) == 0) game_en = ~game_en;
         pixel = ($urandom_range(0, 1) == 1);
         prbs_val = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 20))};
         kill = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         if (spawn_bus.spawn_req) spawn_bus.spawn_ack = ($urandom_range(0, 1) == 1);
         else spawn_bus.spawn_ack = ($urandom_range(0, 7) == 0);
         step();
      end
      spawn_bus.spawn_ack = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
